// File: rtl/reg_read_collector.sv
// Register-read collector: accepts one instruction, schedules per-bank reads
// around bank conflicts, and presents the collected operands to execute.
module reg_read_collector #(
    parameter int TotalNumBank = 8,
    parameter int AddrWidth    = 5,
    parameter int DataWidth    = 32,
    parameter int BankBits     = $clog2(TotalNumBank)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              instrValid,
    output logic                              instrReady,
    input  logic [127:0]                      instr,
    output logic [TotalNumBank-1:0]           readEn,
    output logic [TotalNumBank*AddrWidth-1:0] readAddr,
    input  logic [TotalNumBank*DataWidth-1:0] bankData,
    output logic                              outValid,
    input  logic                              outReady,
    output logic [127:0]                      outInstr,
    output logic [DataWidth-1:0]              opData1,
    output logic [DataWidth-1:0]              opData2,
    output logic [DataWidth-1:0]              opData3,
    output logic [2:0]                        opMask,
    output logic [15:0]                       conflictCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [127:0]         instr_q, instr_d;
    logic [BankBits-1:0]  bank_q [3];
    logic [BankBits-1:0]  bank_d [3];
    logic [AddrWidth-1:0] rsel_q [3];
    logic [AddrWidth-1:0] rsel_d [3];
    logic [DataWidth-1:0] opdata_q [3];
    logic [DataWidth-1:0] opdata_d [3];
    logic [2:0]           mask_q, mask_d;
    logic [2:0]           pending_q, pending_d;
    logic [2:0]           inflight_q, inflight_d;
    logic [15:0]          conflict_q, conflict_d;

    logic [TotalNumBank-1:0] claimed;
    logic [AddrWidth-1:0]    claim_addr [TotalNumBank];
    logic [DataWidth-1:0]    bank_data_arr [TotalNumBank];
    logic [2:0]              grant;
    logic                    denied;
    logic [2:0]              new_mask;

    genvar gi;
    generate
        for (gi = 0; gi < TotalNumBank; gi++) begin : g_bank
            assign bank_data_arr[gi]                   = bankData[gi*DataWidth +: DataWidth];
            assign readEn[gi]                          = claimed[gi];
            assign readAddr[gi*AddrWidth +: AddrWidth] = claim_addr[gi];
        end
    endgenerate

    always_comb begin
        case (instr[7:0])
            8'd1:       new_mask = 3'b011;
            8'd2:       new_mask = 3'b111;
            8'd4, 8'd8: new_mask = 3'b001;
            default:    new_mask = 3'b000;
        endcase
    end

    // Bank arbitration: earlier operands win; a later operand piggybacks on a
    // claimed bank only when it wants the very same register.
    always_comb begin
        claimed = '0;
        grant   = '0;
        denied  = 1'b0;
        for (int b = 0; b < TotalNumBank; b++) claim_addr[b] = '0;
        if (state_q == READ) begin
            for (int i = 0; i < 3; i++) begin
                if (pending_q[i]) begin
                    if (!claimed[bank_q[i]]) begin
                        claimed[bank_q[i]]    = 1'b1;
                        claim_addr[bank_q[i]] = rsel_q[i];
                        grant[i]              = 1'b1;
                    end else if (claim_addr[bank_q[i]] == rsel_q[i]) begin
                        grant[i] = 1'b1;
                    end else begin
                        denied = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        mask_d     = mask_q;
        pending_d  = pending_q;
        inflight_d = inflight_q;
        conflict_d = conflict_q;
        for (int i = 0; i < 3; i++) begin
            bank_d[i]   = bank_q[i];
            rsel_d[i]   = rsel_q[i];
            opdata_d[i] = opdata_q[i];
        end
        case (state_q)
            IDLE: begin
                if (instrValid && instrReady) begin
                    instr_d    = instr;
                    mask_d     = new_mask;
                    pending_d  = new_mask;
                    inflight_d = '0;
                    bank_d[0]  = instr[17 +: BankBits];
                    bank_d[1]  = instr[22 +: BankBits];
                    bank_d[2]  = instr[27 +: BankBits];
                    rsel_d[0]  = instr[64 +: AddrWidth];
                    rsel_d[1]  = instr[88 +: AddrWidth];
                    rsel_d[2]  = instr[104 +: AddrWidth];
                    for (int i = 0; i < 3; i++) opdata_d[i] = '0;
                    state_d = (new_mask != 3'b000) ? READ : DONE;
                end
            end
            READ: begin
                for (int i = 0; i < 3; i++) begin
                    if (inflight_q[i]) opdata_d[i] = bank_data_arr[bank_q[i]];
                end
                pending_d  = pending_q & ~grant;
                inflight_d = grant;
                if (denied && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
                if (pending_d == 3'b000 && grant == 3'b000) state_d = DONE;
            end
            DONE: begin
                if (outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            mask_q     <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
            conflict_q <= '0;
            for (int i = 0; i < 3; i++) begin
                bank_q[i]   <= '0;
                rsel_q[i]   <= '0;
                opdata_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            conflict_q <= conflict_d;
            for (int i = 0; i < 3; i++) begin
                bank_q[i]   <= bank_d[i];
                rsel_q[i]   <= rsel_d[i];
                opdata_q[i] <= opdata_d[i];
            end
        end
    end

    assign instrReady    = (state_q == IDLE) && !rst;
    assign outValid      = (state_q == DONE);
    assign outInstr      = instr_q;
    assign opData1       = opdata_q[0];
    assign opData2       = opdata_q[1];
    assign opData3       = opdata_q[2];
    assign opMask        = mask_q;
    assign conflictCount = conflict_q;

endmodule

// File: tb/tb_reg_read_collector.sv
// Directed bench for reg_read_collector; a bank model returns
// 32'hB0 + bank + (addr << 8) one cycle after each strobe, DEAD0000 otherwise.
module tb_reg_read_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         instrValid;
    logic         instrReady;
    logic [127:0] instr;
    logic [7:0]   readEn;
    logic [39:0]  readAddr;
    logic [255:0] bankData;
    logic         outValid;
    logic         outReady;
    logic [127:0] outInstr;
    logic [31:0]  opData1, opData2, opData3;
    logic [2:0]   opMask;
    logic [15:0]  conflictCount;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  en_hist   [20];
    logic [39:0] addr_hist [20];
    int          lat;

    reg_read_collector dut (
        .clk(clk), .rst(rst), .instrValid(instrValid), .instrReady(instrReady),
        .instr(instr), .readEn(readEn), .readAddr(readAddr), .bankData(bankData),
        .outValid(outValid), .outReady(outReady), .outInstr(outInstr),
        .opData1(opData1), .opData2(opData2), .opData3(opData3),
        .opMask(opMask), .conflictCount(conflictCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            bankData[b*32 +: 32] <= readEn[b] ? (32'hB0 + b + ({27'd0, readAddr[b*5 +: 5]} << 8))
                                              : 32'hDEAD0000;
        end
    end

    function automatic logic [127:0] mk(input logic [7:0] op, input logic [2:0] b1, b2, b3,
                                        input logic [7:0] r1, r2, r3, input logic [15:0] tag);
        logic [127:0] v;
        v = '0;
        v[7:0] = op;   v[19:17] = b1;  v[24:22] = b2;   v[29:27] = b3;
        v[71:64] = r1; v[95:88] = r2;  v[111:104] = r3; v[127:112] = tag;
        return v;
    endfunction

    // Offer w, wait for the accept edge, then log strobes until outValid (bounded).
    task automatic send_and_wait(input logic [127:0] w);
        instr = w;
        instrValid = 1'b1;
        @(posedge clk); #1;
        instrValid = 1'b0;
        for (int i = 0; i < 20; i++) begin en_hist[i] = '0; addr_hist[i] = '0; end
        lat = 1;
        while (!outValid && lat < 20) begin
            en_hist[lat-1]   = readEn;
            addr_hist[lat-1] = readAddr;
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (!outValid) begin
            miscompares++;
            $display("FAIL timeout: outValid not seen within %0d cycles", lat);
        end
        $display("txn instr=%h latency=%0d mask=%b op=%h/%h/%h conflicts=%0d",
                 w, lat, opMask, opData1, opData2, opData3, conflictCount);
    endtask

    task automatic release_out();
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        vectors++;
        if (outValid !== 1'b0 || instrReady !== 1'b1) begin
            miscompares++;
            $display("FAIL release: outValid=%b instrReady=%b, want 0/1", outValid, instrReady);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instrValid = 1'b0; outReady = 1'b0; instr = '0;
        @(posedge clk); @(posedge clk); #1;
        vectors++;
        if (instrReady !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: instrReady=%b want 0", instrReady);
        end
        vectors++;
        if (outValid !== 1'b0 || readEn !== 8'h0 || readAddr !== 40'h0 || outInstr !== 128'h0 ||
            opData1 !== 32'h0 || opData2 !== 32'h0 || opData3 !== 32'h0 || opMask !== 3'b000 ||
            conflictCount !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: outValid=%b readEn=%h mask=%b cc=%0d want all 0",
                     outValid, readEn, opMask, conflictCount);
        end
        rst = 1'b0; #1;
        vectors++;
        if (instrReady !== 1'b1) begin
            miscompares++; $display("FAIL reset_release: instrReady=%b want 1", instrReady);
        end
    endtask

    task automatic test_basic(input string nm);
        logic [127:0] w;
        w = mk(8'd2, 3'd1, 3'd2, 3'd3, 8'd4, 8'd5, 8'd6, 16'h1111);
        send_and_wait(w);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL %s_latency: %0d want 3", nm, lat); end
        vectors++;
        if (en_hist[0] !== 8'b00001110 || en_hist[1] !== 8'h00) begin
            miscompares++;
            $display("FAIL %s_readen: %b,%b want 00001110,00000000", nm, en_hist[0], en_hist[1]);
        end
        vectors++;
        if (addr_hist[0][5 +: 5] !== 5'd4 || addr_hist[0][10 +: 5] !== 5'd5 || addr_hist[0][15 +: 5] !== 5'd6) begin
            miscompares++; $display("FAIL %s_addr: readAddr=%h want banks1..3 = 4,5,6", nm, addr_hist[0]);
        end
        vectors++;
        if (opData1 !== 32'h4B1 || opData2 !== 32'h5B2 || opData3 !== 32'h6B3) begin
            miscompares++;
            $display("FAIL %s_data: %h/%h/%h want 4b1/5b2/6b3", nm, opData1, opData2, opData3);
        end
        vectors++;
        if (opMask !== 3'b111 || outInstr !== w || conflictCount !== 16'd0) begin
            miscompares++;
            $display("FAIL %s_meta: mask=%b cc=%0d instr=%h want 111/0/%h", nm, opMask, conflictCount, outInstr, w);
        end
        release_out();
    endtask

    task automatic test_conflict();
        send_and_wait(mk(8'd2, 3'd2, 3'd2, 3'd4, 8'd3, 8'd5, 8'd1, 16'h2222));
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL conflict_latency: %0d want 4", lat); end
        vectors++;
        if (en_hist[0] !== 8'b00010100 || addr_hist[0][10 +: 5] !== 5'd3 || addr_hist[0][20 +: 5] !== 5'd1) begin
            miscompares++;
            $display("FAIL conflict_cycle1: en=%b addr=%h want 00010100 b2=3 b4=1", en_hist[0], addr_hist[0]);
        end
        vectors++;
        if (en_hist[1] !== 8'b00000100 || addr_hist[1][10 +: 5] !== 5'd5 || en_hist[2] !== 8'h00) begin
            miscompares++;
            $display("FAIL conflict_cycle2: en=%b addr=%h en3=%b want 00000100 b2=5 then 0",
                     en_hist[1], addr_hist[1], en_hist[2]);
        end
        vectors++;
        if (opData1 !== 32'h3B2 || opData2 !== 32'h5B2 || opData3 !== 32'h1B4 || conflictCount !== 16'd1) begin
            miscompares++;
            $display("FAIL conflict_data: %h/%h/%h cc=%0d want 3b2/5b2/1b4 cc=1",
                     opData1, opData2, opData3, conflictCount);
        end
        release_out();
    endtask

    task automatic test_merge();
        send_and_wait(mk(8'd1, 3'd6, 3'd6, 3'd6, 8'd9, 8'h29, 8'd17, 16'h3333));
        vectors++;
        if (lat !== 3 || en_hist[0] !== 8'b01000000 || addr_hist[0][30 +: 5] !== 5'd9 || en_hist[1] !== 8'h00) begin
            miscompares++;
            $display("FAIL merge_reads: lat=%0d en=%b,%b addr=%h want 3 01000000,0 b6=9",
                     lat, en_hist[0], en_hist[1], addr_hist[0]);
        end
        vectors++;
        if (opData1 !== 32'h9B6 || opData2 !== 32'h9B6 || opData3 !== 32'h0 || opMask !== 3'b011 ||
            conflictCount !== 16'd1) begin
            miscompares++;
            $display("FAIL merge_data: %h/%h/%h mask=%b cc=%0d want 9b6/9b6/0 011 cc=1",
                     opData1, opData2, opData3, opMask, conflictCount);
        end
        release_out();
    endtask

    task automatic test_zero_operand();
        send_and_wait(mk(8'd7, 3'd1, 3'd2, 3'd3, 8'd1, 8'd2, 8'd3, 16'h4444));
        vectors++;
        if (lat !== 1 || en_hist[0] !== 8'h00) begin
            miscompares++; $display("FAIL zero_latency: lat=%0d en=%b want 1, 0", lat, en_hist[0]);
        end
        vectors++;
        if (opMask !== 3'b000 || opData1 !== 32'h0 || opData2 !== 32'h0 || opData3 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_data: mask=%b %h/%h/%h want 000 0/0/0", opMask, opData1, opData2, opData3);
        end
        release_out();
    endtask

    task automatic test_hold();
        logic [127:0] w;
        w = mk(8'd4, 3'd5, 3'd0, 3'd0, 8'd7, 8'd0, 8'd0, 16'h5555);
        send_and_wait(w);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (outValid !== 1'b1 || instrReady !== 1'b0 || outInstr !== w || opData1 !== 32'h7B5 ||
                opData2 !== 32'h0 || opData3 !== 32'h0 || opMask !== 3'b001 || readEn !== 8'h0) begin
                miscompares++;
                $display("FAIL hold_c%0d: v=%b rdy=%b op1=%h mask=%b en=%b want 1 0 7b5 001 0",
                         c, outValid, instrReady, opData1, opMask, readEn);
            end
            @(posedge clk); #1;
        end
        release_out();
    endtask

    task automatic test_reset_in_read();
        instr = mk(8'd2, 3'd2, 3'd2, 3'd4, 8'd3, 8'd5, 8'd1, 16'h6666);
        instrValid = 1'b1;
        @(posedge clk); #1;
        instrValid = 1'b0;
        vectors++;
        if (readEn === 8'h00) begin
            miscompares++; $display("FAIL abort_inread: readEn=%b want nonzero", readEn);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (outValid !== 1'b0 || instrReady !== 1'b0 || readEn !== 8'h0 || readAddr !== 40'h0 ||
            outInstr !== 128'h0 || opData1 !== 32'h0 || opData2 !== 32'h0 || opData3 !== 32'h0 ||
            opMask !== 3'b000 || conflictCount !== 16'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: v=%b rdy=%b en=%b mask=%b cc=%0d want all 0",
                     outValid, instrReady, readEn, opMask, conflictCount);
        end
        rst = 1'b0; #1;
        vectors++;
        if (instrReady !== 1'b1) begin
            miscompares++; $display("FAIL abort_ready: instrReady=%b want 1", instrReady);
        end
        test_basic("fresh");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_conflict();
        test_merge();
        test_zero_operand();
        test_hold();
        test_reset_in_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
